// File: rtl/bpi_flash_responder.sv
// Flash emulator for the far end of the BPI bus: decodes synchronized strobe cycles and
// runs a reduced P30 command set (read array/status/ID, word program, block erase) on an internal array.
module bpi_flash_responder #(
    parameter int          MEM_AW   = 10,
    parameter int          BLK_AW   = 6,
    parameter int          PGM_DLY  = 16,
    parameter int          ERS_DLY  = 64,
    parameter int          READ_LAT = 2,
    parameter logic [15:0] DEV_ID   = 16'h891C
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic [22:0] BPI_AD,
    input  logic [15:0] DQ_IN,
    output logic [15:0] DQ_OUT,
    output logic        DQ_OE,
    input  logic        FCS_B,
    input  logic        FOE_B,
    input  logic        FWE_B,
    input  logic        FLATCH_B,
    output logic        READY,
    output logic [7:0]  STATUS
);

    localparam int CNT_MAX_A = (PGM_DLY > ERS_DLY) ? PGM_DLY : ERS_DLY;
    localparam int CNT_MAX   = (CNT_MAX_A > (1 << BLK_AW)) ? CNT_MAX_A : (1 << BLK_AW);
    localparam int CW        = $clog2(CNT_MAX) + 1;
    localparam int RW        = $clog2(READ_LAT) + 1;

    localparam int I_CS = 0, I_OE = 1, I_WE = 2, I_LATCH = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_PGM_SETUP, S_PGM_RD, S_PGM_WR, S_PGM_WAIT,
        S_ERS_SETUP, S_ERS_CLR, S_ERS_WAIT, S_LOCK_SETUP
    } state_t;

    typedef enum logic [1:0] {M_ARRAY, M_STATUS, M_ID} mode_t;

    logic [3:0]        strobe_pins;
    logic [3:0]        sync1_reg, sync2_reg, prev_reg;
    logic [3:0]        rise;
    logic [MEM_AW-1:0] shadow_ad_reg;
    logic [15:0]       shadow_dq_reg;
    logic [MEM_AW-1:0] addr_reg;
    logic [MEM_AW-1:0] wr_addr;
    logic              latch_commit, cmd_valid, rd_act;
    logic [7:0]        cmd_byte;

    state_t            state_reg, state_next;
    mode_t             mode_reg, mode_next;
    logic [MEM_AW-1:0] op_addr_reg, op_addr_next;
    logic [15:0]       op_data_reg, op_data_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              pgm_err_reg, pgm_err_next;
    logic              ers_err_reg, ers_err_next;
    logic              busy;
    logic [7:0]        status;

    logic [RW-1:0]     rd_cnt_reg;
    logic              dq_oe_reg;
    logic [15:0]       dq_out_reg, dq_out_next;

    logic [15:0]       mem [0:(1 << MEM_AW) - 1];
    logic [15:0]       mem_rd_reg;
    logic [MEM_AW-1:0] rd_addr;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [15:0]       mem_wd;

    // Upper address bits are deliberately ignored (array wraps).
    logic unused_bits;
    assign unused_bits = ^BPI_AD[22:MEM_AW];

    assign strobe_pins = {FLATCH_B, FWE_B, FOE_B, FCS_B};
    assign rise        = sync2_reg & ~prev_reg;
    assign rd_act      = ~sync2_reg[I_CS] & ~sync2_reg[I_OE];

    // Chip-select is qualified with its previous synced value so a strobe and FCS_B
    // rising together still count as a cycle.
    assign latch_commit = rise[I_LATCH] & ~prev_reg[I_CS];
    assign cmd_valid    = rise[I_WE] & ~prev_reg[I_CS] & sync2_reg[I_OE];
    assign cmd_byte     = shadow_dq_reg[7:0];
    assign wr_addr      = latch_commit ? shadow_ad_reg : addr_reg;

    assign busy   = (state_reg == S_PGM_RD) || (state_reg == S_PGM_WR) ||
                    (state_reg == S_PGM_WAIT) || (state_reg == S_ERS_CLR) ||
                    (state_reg == S_ERS_WAIT);
    assign status = {~busy, 1'b0, ers_err_reg, pgm_err_reg, 4'h0};

    assign READY  = ~busy;
    assign STATUS = status;
    assign DQ_OUT = dq_out_reg;
    assign DQ_OE  = dq_oe_reg;

    assign rd_addr = (state_reg == S_PGM_RD) ? op_addr_reg : addr_reg;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        mem_rd_reg <= mem[rd_addr];
    end

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        op_addr_next = op_addr_reg;
        op_data_next = op_data_reg;
        cnt_next     = cnt_reg;
        pgm_err_next = pgm_err_reg;
        ers_err_next = ers_err_reg;
        mem_we       = 1'b0;
        mem_wa       = op_addr_reg;
        mem_wd       = 16'hFFFF;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_byte)
                        8'hFF: mode_next = M_ARRAY;
                        8'h70: mode_next = M_STATUS;
                        8'h90: mode_next = M_ID;
                        8'h50: begin
                            pgm_err_next = 1'b0;
                            ers_err_next = 1'b0;
                        end
                        8'h40, 8'h10: state_next = S_PGM_SETUP;
                        8'h20: state_next = S_ERS_SETUP;
                        8'h60: state_next = S_LOCK_SETUP;
                        default: ;
                    endcase
                end
            end
            S_PGM_SETUP: begin
                if (cmd_valid) begin
                    op_addr_next = wr_addr;
                    op_data_next = shadow_dq_reg;
                    mode_next    = M_STATUS;
                    state_next   = S_PGM_RD;
                end
            end
            S_PGM_RD: state_next = S_PGM_WR;
            S_PGM_WR: begin
                // Flash programming can only clear bits; asking for a 0->1 is an error.
                mem_we   = 1'b1;
                mem_wd   = mem_rd_reg & op_data_reg;
                if (|(op_data_reg & ~mem_rd_reg)) begin
                    pgm_err_next = 1'b1;
                end
                cnt_next   = '0;
                state_next = S_PGM_WAIT;
            end
            S_PGM_WAIT: begin
                if (cnt_reg == CW'(PGM_DLY - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ERS_SETUP: begin
                if (cmd_valid) begin
                    mode_next = M_STATUS;
                    if (cmd_byte == 8'hD0) begin
                        op_addr_next = wr_addr;
                        cnt_next     = '0;
                        state_next   = S_ERS_CLR;
                    end else begin
                        pgm_err_next = 1'b1;
                        ers_err_next = 1'b1;
                        state_next   = S_IDLE;
                    end
                end
            end
            S_ERS_CLR: begin
                mem_we = 1'b1;
                mem_wa = {op_addr_reg[MEM_AW-1:BLK_AW], cnt_reg[BLK_AW-1:0]};
                if (cnt_reg == CW'((1 << BLK_AW) - 1)) begin
                    cnt_next   = '0;
                    state_next = S_ERS_WAIT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ERS_WAIT: begin
                if (cnt_reg == CW'(ERS_DLY - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_LOCK_SETUP: begin
                if (cmd_valid) begin
                    mode_next  = M_STATUS;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dq_out_next = {8'h00, status};
        if (!busy) begin
            case (mode_reg)
                M_ARRAY: dq_out_next = mem_rd_reg;
                M_ID: begin
                    if (addr_reg == MEM_AW'(0)) begin
                        dq_out_next = 16'h0089;
                    end else if (addr_reg == MEM_AW'(1)) begin
                        dq_out_next = DEV_ID;
                    end else begin
                        dq_out_next = 16'h0000;
                    end
                end
                default: dq_out_next = {8'h00, status};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            sync1_reg     <= '1;
            sync2_reg     <= '1;
            prev_reg      <= '1;
            shadow_ad_reg <= '0;
            shadow_dq_reg <= '0;
            addr_reg      <= '0;
            state_reg     <= S_IDLE;
            mode_reg      <= M_ARRAY;
            op_addr_reg   <= '0;
            op_data_reg   <= '0;
            cnt_reg       <= '0;
            pgm_err_reg   <= 1'b0;
            ers_err_reg   <= 1'b0;
            rd_cnt_reg    <= '0;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
        end else begin
            sync1_reg <= strobe_pins;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (!sync2_reg[I_LATCH]) begin
                shadow_ad_reg <= BPI_AD[MEM_AW-1:0];
            end
            if (!sync2_reg[I_WE]) begin
                shadow_dq_reg <= DQ_IN;
            end
            if (latch_commit) begin
                addr_reg <= shadow_ad_reg;
            end
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            op_addr_reg <= op_addr_next;
            op_data_reg <= op_data_next;
            cnt_reg     <= cnt_next;
            pgm_err_reg <= pgm_err_next;
            ers_err_reg <= ers_err_next;
            // rd_cnt counts cycles of active read; OE asserts READ_LAT cycles after it starts.
            if (rd_act) begin
                if (rd_cnt_reg != RW'(READ_LAT - 1)) begin
                    rd_cnt_reg <= rd_cnt_reg + 1'b1;
                end
                dq_oe_reg <= (rd_cnt_reg == RW'(READ_LAT - 1));
            end else begin
                rd_cnt_reg <= '0;
                dq_oe_reg  <= 1'b0;
            end
            dq_out_reg <= dq_out_next;
        end
    end

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Randomized bus-level bench for bpi_flash_responder, checked against a command-level
// flash model (array contents, read mode, pending setup command and sticky error bits).
module tb_bpi_flash_responder;

    localparam int          MEM_AW   = 10;
    localparam int          BLK_AW   = 6;
    localparam int          PGM_DLY  = 16;
    localparam int          ERS_DLY  = 64;
    localparam int          READ_LAT = 2;
    localparam logic [15:0] DEV_ID   = 16'h891C;
    localparam int          WORDS    = 1 << MEM_AW;
    localparam int          BLK      = 1 << BLK_AW;

    logic        CLK = 1'b0;
    logic        RST_B = 1'b0;
    logic [22:0] BPI_AD = '0;
    logic [15:0] DQ_IN = '0;
    logic [15:0] DQ_OUT;
    logic        DQ_OE;
    logic        FCS_B = 1'b1;
    logic        FOE_B = 1'b1;
    logic        FWE_B = 1'b1;
    logic        FLATCH_B = 1'b1;
    logic        READY;
    logic [7:0]  STATUS;

    bpi_flash_responder #(
        .MEM_AW(MEM_AW), .BLK_AW(BLK_AW), .PGM_DLY(PGM_DLY), .ERS_DLY(ERS_DLY),
        .READ_LAT(READ_LAT), .DEV_ID(DEV_ID)
    ) dut (
        .CLK(CLK), .RST_B(RST_B), .BPI_AD(BPI_AD), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT),
        .DQ_OE(DQ_OE), .FCS_B(FCS_B), .FOE_B(FOE_B), .FWE_B(FWE_B), .FLATCH_B(FLATCH_B),
        .READY(READY), .STATUS(STATUS)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=array 1=status 2=id; pend 0=none 1=program 2=erase 3=lock
    logic [15:0] m_mem [WORDS];
    int          m_mode = 0;
    int          m_pend = 0;
    bit          m_perr = 1'b0;
    bit          m_eerr = 1'b0;

    function automatic logic [7:0] m_status(input bit busy);
        return {~busy, 1'b0, m_eerr, m_perr, 4'h0};
    endfunction

    function automatic logic [15:0] m_read(input int a);
        int w;
        w = a % WORDS;
        if (m_mode == 1) return {8'h00, m_status(1'b0)};
        if (m_mode == 2) return (w == 0) ? 16'h0089 : (w == 1) ? DEV_ID : 16'h0000;
        return m_mem[w];
    endfunction

    task automatic model_write(input int a, input logic [15:0] d, output bit started);
        int w;
        w = a % WORDS;
        started = 1'b0;
        case (m_pend)
            1: begin
                if ((d & ~m_mem[w]) != 16'h0) m_perr = 1'b1;
                m_mem[w] = m_mem[w] & d;
                m_mode = 1; m_pend = 0; started = 1'b1;
            end
            2: begin
                if (d[7:0] == 8'hD0) begin
                    for (int i = 0; i < BLK; i++) m_mem[(w / BLK) * BLK + i] = 16'hFFFF;
                    started = 1'b1;
                end else begin
                    m_perr = 1'b1; m_eerr = 1'b1;
                end
                m_mode = 1; m_pend = 0;
            end
            3: begin
                m_mode = 1; m_pend = 0;
            end
            default: begin
                case (d[7:0])
                    8'hFF: m_mode = 0;
                    8'h70: m_mode = 1;
                    8'h90: m_mode = 2;
                    8'h50: begin m_perr = 1'b0; m_eerr = 1'b0; end
                    8'h40, 8'h10: m_pend = 1;
                    8'h20: m_pend = 2;
                    8'h60: m_pend = 3;
                    default: ;
                endcase
            end
        endcase
    endtask

    // Address latch and write strobe rise together, exercising latch-before-write.
    task automatic bus_write(input logic [22:0] a, input logic [15:0] d, input bit oe_low = 1'b0);
        @(negedge CLK);
        BPI_AD = a; DQ_IN = d;
        FCS_B = 1'b0; FLATCH_B = 1'b0; FWE_B = 1'b0; FOE_B = oe_low ? 1'b0 : 1'b1;
        repeat (5) @(negedge CLK);
        FLATCH_B = 1'b1; FWE_B = 1'b1;
        repeat (4) @(negedge CLK);
        FCS_B = 1'b1; FOE_B = 1'b1;
        repeat (2) @(negedge CLK);
        $display("txn write addr=%06h data=%04h oe_low=%0d", a, d, oe_low);
    endtask

    task automatic bus_read(input logic [22:0] a, output logic [15:0] d);
        int k;
        @(negedge CLK);
        BPI_AD = a; FCS_B = 1'b0; FLATCH_B = 1'b0;
        repeat (4) @(negedge CLK);
        FLATCH_B = 1'b1;
        repeat (3) @(negedge CLK);
        FOE_B = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            k++;
            if (DQ_OE === 1'b1) break;
        end
        chk("oe_on_latency", k, READ_LAT + 2);
        repeat (4) @(negedge CLK);
        d = DQ_OUT;
        FOE_B = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            k++;
            if (DQ_OE === 1'b0) break;
        end
        chk("oe_off_latency", k, 3);
        FCS_B = 1'b1;
        repeat (2) @(negedge CLK);
        $display("txn read  addr=%06h data=%04h", a, d);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (k < 3000 && READY !== 1'b1) begin
            @(negedge CLK);
            k++;
        end
        chk("ready_timeout", READY, 1'b1);
    endtask

    task automatic flash_cmd(input logic [22:0] a, input logic [15:0] d);
        bit started;
        bus_write(a, d);
        model_write(int'(a), d, started);
        if (started) begin
            chk("busy_ready", READY, 1'b0);
            chk("busy_status", STATUS, m_status(1'b1));
            wait_ready();
        end
    endtask

    task automatic check_read(input logic [22:0] a);
        logic [15:0] d;
        bus_read(a, d);
        chk($sformatf("read@%06h", a), d, m_read(int'(a)));
    endtask

    initial begin
        logic [15:0] rd;
        logic [22:0] ra;
        bit started;
        int k;

        repeat (3) @(negedge CLK);
        chk("rst_dq_out", DQ_OUT, 16'h0000);
        chk("rst_dq_oe", DQ_OE, 1'b0);
        chk("rst_ready", READY, 1'b1);
        chk("rst_status", STATUS, 8'h80);
        RST_B = 1'b1;
        repeat (3) @(negedge CLK);

        // Erase the whole array so the model has known contents.
        for (int b = 0; b < WORDS / BLK; b++) begin
            flash_cmd(23'(b * BLK), 16'h0020);
            flash_cmd(23'(b * BLK), 16'h00D0);
        end
        check_read(23'd0);
        flash_cmd(23'd0, 16'h00FF);
        check_read(23'd0);

        // Random word programs, read back directly and through wrapped addresses.
        for (int n = 0; n < 24; n++) begin
            int a;
            logic [15:0] d;
            a = $urandom_range(0, WORDS - 1);
            d = 16'($urandom);
            flash_cmd(23'(a), ($urandom_range(0, 1) == 1) ? 16'h0040 : 16'h0010);
            flash_cmd(23'(a), d);
            check_read(23'(a));
            if (m_perr) begin
                flash_cmd(23'(a), 16'h0050);
                check_read(23'(a));
            end
            flash_cmd(23'(a), 16'h00FF);
            check_read(23'(a));
            ra = {13'($urandom), 10'(a)};
            check_read(ra);
        end

        // Second program asking for 0->1 sets the program error.
        flash_cmd(23'd7, 16'h0040);
        flash_cmd(23'd7, 16'h00F0);
        flash_cmd(23'd7, 16'h0040);
        flash_cmd(23'd7, 16'h000F);
        check_read(23'd7);
        flash_cmd(23'd0, 16'h0050);
        check_read(23'd7);
        flash_cmd(23'd0, 16'h00FF);
        check_read(23'd7);

        // Block 1 erase with neighbours programmed; a write during busy is dropped.
        flash_cmd(23'd63, 16'h0040);  flash_cmd(23'd63, 16'h1234);
        flash_cmd(23'd128, 16'h0040); flash_cmd(23'd128, 16'h5678);
        flash_cmd(23'd100, 16'h0040); flash_cmd(23'd100, 16'h0000);
        bus_write(23'd64, 16'h0020);
        model_write(64, 16'h0020, started);
        bus_write(23'd64, 16'h00D0);
        model_write(64, 16'h00D0, started);
        chk("erase_busy", READY, 1'b0);
        bus_write(23'd0, 16'h00FF);
        wait_ready();
        check_read(23'd64);
        flash_cmd(23'd0, 16'h00FF);
        check_read(23'd63);
        check_read(23'd64);
        check_read(23'd100);
        check_read(23'd127);
        check_read(23'd128);

        // Erase confirm with a wrong code.
        flash_cmd(23'd5, 16'h0020);
        flash_cmd(23'd5, 16'h00FF);
        check_read(23'd5);
        flash_cmd(23'd0, 16'h00FF);
        check_read(23'd5);
        flash_cmd(23'd0, 16'h0070);
        check_read(23'd5);
        flash_cmd(23'd0, 16'h0050);
        check_read(23'd5);

        // Lock setup sequence only switches to status mode.
        flash_cmd(23'd3, 16'h0060);
        flash_cmd(23'd3, 16'h0001);
        check_read(23'd3);

        // Read-ID, including a wrapped offset.
        flash_cmd(23'd0, 16'h0090);
        check_read(23'd0);
        check_read(23'd1);
        check_read(23'd2);
        check_read(23'(WORDS + 1));

        // Write cycle with FOE_B low must be ignored.
        flash_cmd(23'd0, 16'h00FF);
        bus_write(23'd0, 16'h0070, 1'b1);
        check_read(23'd9);

        // Reset in the middle of an erase while a read is being driven.
        bus_write(23'(2 * BLK), 16'h0020);
        model_write(2 * BLK, 16'h0020, started);
        bus_write(23'(2 * BLK), 16'h00D0);
        model_write(2 * BLK, 16'h00D0, started);
        @(negedge CLK);
        FCS_B = 1'b0; FOE_B = 1'b0;
        k = 0;
        while (k < 20 && DQ_OE !== 1'b1) begin
            @(negedge CLK);
            k++;
        end
        chk("pre_rst_oe", DQ_OE, 1'b1);
        chk("pre_rst_ready", READY, 1'b0);
        #2 RST_B = 1'b0;
        #1;
        chk("mid_rst_ready", READY, 1'b1);
        chk("mid_rst_dq_oe", DQ_OE, 1'b0);
        chk("mid_rst_status", STATUS, 8'h80);
        chk("mid_rst_dq_out", DQ_OUT, 16'h0000);
        FCS_B = 1'b1; FOE_B = 1'b1;
        m_mode = 0; m_pend = 0; m_perr = 1'b0; m_eerr = 1'b0;
        repeat (3) @(negedge CLK);
        RST_B = 1'b1;
        repeat (3) @(negedge CLK);
        check_read(23'd0);
        check_read(23'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
